// File: rtl/disp_pkg.sv
// Shared definitions for the display path: blanking level, default scan divider,
// one-hot index helper and the 7-segment glyph table used by the digit decoders.
package disp_pkg;

    // Logical "segment off" bit; replicate to the code width where needed.
    localparam logic SEG_BLANK = 1'b0;

    // Clocks per digit slot when the integrator does not override it.
    localparam int DIG_DEFAULT_DIV = 1000;

    // Maximum strobe width supported by the index helper.
    localparam int MAX_DIG = 16;

    // Index of the set bit of a one-hot vector; returns 0 for an all-zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_DIG-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_DIG; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

    // Hex nibble to segment code, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// Combinational AND-OR selector: picks the W-bit lane whose select bit is set,
// and yields the blank code when no select bit is set.
module onehot_mux
    import disp_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 7
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   y
);

    logic [W-1:0] term [N];

    // Each lane is gated by its own select bit, so a zero select gives a blank, never x.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign term[gi] = sel[gi] ? data[gi*W +: W] : {W{SEG_BLANK}};
        end
    endgenerate

    always_comb begin
        y = {W{SEG_BLANK}};
        for (int i = 0; i < N; i++) begin
            y = y | term[i];
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Autonomous multiplexed display scanner: a prescaler steps a one-hot digit strobe
// every DIV clocks and the selected digit's code is driven out through registers.
module seg_scan_mux
    import disp_pkg::*;
#(
    parameter int N_DIG      = 8,
    parameter int W          = 7,
    parameter int DIV        = DIG_DEFAULT_DIV,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DIG*W-1:0] data_i,
    input  logic [N_DIG-1:0]   en_i,
    input  logic               hold_i,
    output logic [W-1:0]       seg_o,
    output logic [N_DIG-1:0]   an_o,
    output logic               tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N_DIG-1:0] scan_reg, scan_next;
    logic             advance;

    logic [N_DIG-1:0] an_l;
    logic [W-1:0]     seg_l;

    logic [W-1:0]     seg_reg;
    logic [N_DIG-1:0] an_reg;
    logic             tick_reg;

    always_comb begin
        advance   = 1'b0;
        cnt_next  = cnt_reg;
        scan_next = scan_reg;
        if (!hold_i) begin
            if (cnt_reg == CNT_LAST) begin
                advance   = 1'b1;
                cnt_next  = '0;
                scan_next = {scan_reg[N_DIG-2:0], scan_reg[N_DIG-1]};
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Strobe only the current digit, and only if it is enabled; a disabled digit keeps its slot.
    assign an_l = scan_reg & en_i;

    onehot_mux #(
        .N (N_DIG),
        .W (W)
    ) u_seg_mux (
        .sel  (an_l),
        .data (data_i),
        .y    (seg_l)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            scan_reg <= {{(N_DIG-1){1'b0}}, 1'b1};
            tick_reg <= 1'b0;
            seg_reg  <= {W{ACTIVE_LOW}};
            an_reg   <= {N_DIG{ACTIVE_LOW}};
        end else begin
            cnt_reg  <= cnt_next;
            scan_reg <= scan_next;
            tick_reg <= advance;
            // XOR with the polarity bit maps logical "on" to the board's drive level.
            seg_reg  <= seg_l ^ {W{ACTIVE_LOW}};
            an_reg   <= an_l ^ {N_DIG{ACTIVE_LOW}};
        end
    end

    assign seg_o  = seg_reg;
    assign an_o   = an_reg;
    assign tick_o = tick_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: a slot-counting reference model predicts
// strobe, segment and tick outputs for an active-low and an active-high instance.
module tb_seg_scan_mux;

    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_DIG=4, W=7, ACTIVE_LOW=1
    logic        rst_a = 1'b1;
    logic [27:0] data_a = '0;
    logic [3:0]  en_a = '0;
    logic        hold_a = 1'b0;
    logic [6:0]  seg_a;
    logic [3:0]  an_a;
    logic        tick_a;

    // Instance B: N_DIG=8, W=8, ACTIVE_LOW=0
    logic        rst_b = 1'b1;
    logic [63:0] data_b = '0;
    logic [7:0]  en_b = '0;
    logic        hold_b = 1'b0;
    logic [7:0]  seg_b;
    logic [7:0]  an_b;
    logic        tick_b;

    seg_scan_mux #(.N_DIG(4), .W(7), .DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_a (
        .clk(clk), .rst(rst_a), .data_i(data_a), .en_i(en_a), .hold_i(hold_a),
        .seg_o(seg_a), .an_o(an_a), .tick_o(tick_a)
    );

    seg_scan_mux #(.N_DIG(8), .W(8), .DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_b (
        .clk(clk), .rst(rst_b), .data_i(data_b), .en_i(en_b), .hold_i(hold_b),
        .seg_o(seg_b), .an_o(an_b), .tick_o(tick_b)
    );

    int checks = 0;
    int failures = 0;
    string cur_test = "none";

    // Reference model: elapsed clocks within the slot and the digit number being shown.
    int slot_clk_a = 0, digit_a = 0, ticks_a = 0;
    int slot_clk_b = 0, digit_b = 0;

    // One clock of instance A with full comparison of every output.
    task automatic cycle_a();
        logic [3:0] ea;
        logic [6:0] es;
        logic       et;
        if (rst_a) begin
            ea = 4'hF; es = 7'h7F; et = 1'b0;
        end else begin
            ea = en_a[digit_a] ? 4'(1 << digit_a) : 4'h0;
            es = en_a[digit_a] ? data_a[digit_a*7 +: 7] : 7'h00;
            ea = ~ea;
            es = ~es;
            et = !hold_a && (slot_clk_a == DIV - 1);
        end
        @(posedge clk);
        #1;
        checks += 4;
        if (an_a !== ea) begin
            failures++;
            $display("FAIL %s an_o got=%b exp=%b", cur_test, an_a, ea);
        end
        if (seg_a !== es) begin
            failures++;
            $display("FAIL %s seg_o got=%h exp=%h", cur_test, seg_a, es);
        end
        if (tick_a !== et) begin
            failures++;
            $display("FAIL %s tick_o got=%b exp=%b", cur_test, tick_a, et);
        end
        if ($countones(~an_a) > 1) begin
            failures++;
            $display("FAIL %s an_o_multi got=%b exp=at_most_one_low", cur_test, an_a);
        end
        $display("[%0t] %s A an=%b seg=%h tick=%b", $time, cur_test, an_a, seg_a, tick_a);
        if (tick_a === 1'b1) ticks_a++;
        if (rst_a) begin
            slot_clk_a = 0; digit_a = 0;
        end else if (!hold_a) begin
            if (slot_clk_a == DIV - 1) begin
                slot_clk_a = 0;
                digit_a = (digit_a + 1) % 4;
            end else begin
                slot_clk_a++;
            end
        end
    endtask

    task automatic cycle_b();
        logic [7:0] ea;
        logic [7:0] es;
        logic       et;
        if (rst_b) begin
            ea = 8'h00; es = 8'h00; et = 1'b0;
        end else begin
            ea = en_b[digit_b] ? 8'(1 << digit_b) : 8'h00;
            es = en_b[digit_b] ? data_b[digit_b*8 +: 8] : 8'h00;
            et = !hold_b && (slot_clk_b == DIV - 1);
        end
        @(posedge clk);
        #1;
        checks += 4;
        if (an_b !== ea) begin
            failures++;
            $display("FAIL %s an_o got=%b exp=%b", cur_test, an_b, ea);
        end
        if (seg_b !== es) begin
            failures++;
            $display("FAIL %s seg_o got=%h exp=%h", cur_test, seg_b, es);
        end
        if (tick_b !== et) begin
            failures++;
            $display("FAIL %s tick_o got=%b exp=%b", cur_test, tick_b, et);
        end
        if ($countones(an_b) > 1) begin
            failures++;
            $display("FAIL %s an_o_multi got=%b exp=at_most_one_high", cur_test, an_b);
        end
        $display("[%0t] %s B an=%b seg=%h tick=%b", $time, cur_test, an_b, seg_b, tick_b);
        if (rst_b) begin
            slot_clk_b = 0; digit_b = 0;
        end else if (!hold_b) begin
            if (slot_clk_b == DIV - 1) begin
                slot_clk_b = 0;
                digit_b = (digit_b + 1) % 8;
            end else begin
                slot_clk_b++;
            end
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst_a = 1'b1; hold_a = 1'b0; en_a = 4'hF;
        data_a = {7'h03, 7'h02, 7'h01, 7'h00};
        repeat (2) cycle_a();
        rst_a = 1'b0;
        cycle_a();
        checks++;
        if (an_a !== 4'b1110) begin
            failures++;
            $display("FAIL reset_first_strobe got=%b exp=1110", an_a);
        end
        repeat (4) cycle_a();
        checks++;
        if (an_a !== 4'b1101) begin
            failures++;
            $display("FAIL reset_second_strobe got=%b exp=1101", an_a);
        end
    endtask

    task automatic test_scan_wrap();
        cur_test = "scan_wrap";
        data_a = {7'h03, 7'h02, 7'h01, 7'h00};
        en_a = 4'hF;
        repeat (20) cycle_a();
    endtask

    task automatic test_blanking();
        int t0;
        cur_test = "blank_one";
        en_a = 4'b1011;
        repeat (20) cycle_a();
        cur_test = "blank_all";
        en_a = 4'h0;
        t0 = ticks_a;
        repeat (16) cycle_a();
        checks++;
        if (ticks_a - t0 != 4) begin
            failures++;
            $display("FAIL blank_tick_count got=%0d exp=4", ticks_a - t0);
        end
        en_a = 4'hF;
    endtask

    task automatic test_hold();
        int guard;
        cur_test = "hold";
        data_a = {7'h03, 7'h02, 7'h01, 7'h00};
        guard = 0;
        while (!(digit_a == 1 && slot_clk_a == 2) && guard < 40) begin
            cycle_a();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL hold_wait got=timeout exp=digit1_cnt2");
        end
        hold_a = 1'b1;
        repeat (3) cycle_a();
        data_a[13:7] = 7'h55;
        cycle_a();
        checks++;
        if (seg_a !== ~7'h55) begin
            failures++;
            $display("FAIL hold_data_track got=%h exp=%h", seg_a, ~7'h55);
        end
        repeat (6) cycle_a();
        hold_a = 1'b0;
        repeat (6) cycle_a();
    endtask

    task automatic test_reset_mid();
        int guard;
        cur_test = "reset_mid";
        en_a = 4'hF;
        guard = 0;
        while (!(digit_a == 3 && slot_clk_a == 1) && guard < 40) begin
            cycle_a();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL reset_mid_wait got=timeout exp=digit3");
        end
        hold_a = 1'b1;
        rst_a = 1'b1;
        cycle_a();
        checks++;
        if (an_a !== 4'hF) begin
            failures++;
            $display("FAIL reset_mid_off got=%b exp=1111", an_a);
        end
        rst_a = 1'b0;
        hold_a = 1'b0;
        cycle_a();
        checks++;
        if (an_a !== 4'b1110) begin
            failures++;
            $display("FAIL reset_mid_digit0 got=%b exp=1110", an_a);
        end
        repeat (4) cycle_a();
    endtask

    task automatic test_random();
        cur_test = "random";
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) data_a = 28'($urandom);
            if ($urandom_range(0, 7) == 0) en_a = 4'($urandom_range(0, 15));
            hold_a = ($urandom_range(0, 7) == 0);
            rst_a = ($urandom_range(0, 63) == 0);
            cycle_a();
        end
        rst_a = 1'b0;
        hold_a = 1'b0;
    endtask

    task automatic test_active_high();
        cur_test = "active_high";
        rst_b = 1'b1;
        repeat (2) cycle_b();
        rst_b = 1'b0;
        en_b = 8'hFF;
        data_b = {$urandom, $urandom};
        repeat (40) cycle_b();
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) data_b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) en_b = 8'($urandom);
            hold_b = ($urandom_range(0, 7) == 0);
            cycle_b();
        end
    endtask

    initial begin
        test_reset();
        test_scan_wrap();
        test_blanking();
        test_hold();
        test_reset_mid();
        test_random();
        test_active_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
